// File: rtl/countdown_timer_pkg.sv
// Shared types and limits for the HH:MM:SS countdown timer.
// Build option: define COUNTDOWN_BEEP_EN to enable the expiry beeper.
package countdown_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUN     = 2'd1,
    PAUSED  = 2'd2,
    EXPIRED = 2'd3
  } cd_state_t;

  localparam logic [7:0] MAX_SEC = 8'd59;
  localparam logic [7:0] MAX_MIN = 8'd59;
  localparam logic [7:0] MAX_HRS = 8'd23;

  // Saturate an operator-supplied field value to its legal maximum.
  function automatic logic [7:0] clamp_field(input logic [7:0] val, input logic [7:0] max_val);
    logic [7:0] res;
    if (val > max_val) begin
      res = max_val;
    end else begin
      res = val;
    end
    return res;
  endfunction

endpackage

// File: rtl/countdown_timer_if.sv
// Control/status bundle between the countdown timer and whoever drives it.
interface countdown_timer_if;

  logic       load;
  logic [7:0] load_hrs;
  logic [7:0] load_min;
  logic [7:0] load_sec;
  logic       start;
  logic       pause;
  logic       ack;
  logic [7:0] hrs;
  logic [7:0] min;
  logic [7:0] sec;
  logic       running;
  logic       expired;
  logic       beep;

  modport master (
    output load, load_hrs, load_min, load_sec, start, pause, ack,
    input  hrs, min, sec, running, expired, beep
  );

  modport slave (
    input  load, load_hrs, load_min, load_sec, start, pause, ack,
    output hrs, min, sec, running, expired, beep
  );

endinterface

// File: rtl/countdown_timer_down_field.sv
// One 8-bit binary down-counting time field; wraps to i_max and borrows
// into the next field when decremented from zero.
module down_field (
  input  logic       clk,
  input  logic       reset,
  input  logic       i_dec,
  input  logic       i_load,
  input  logic [7:0] i_load_val,
  input  logic [7:0] i_max,
  output logic [7:0] o_count,
  output logic       o_borrow
);

  logic [7:0] r_count;

  // Field register: reset, parallel load, or decrement with wrap.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_count <= 8'd0;
    end else if (i_load) begin
      r_count <= i_load_val;
    end else if (i_dec) begin
      if (r_count == 8'd0) begin
        r_count <= i_max;
      end else begin
        r_count <= r_count - 8'd1;
      end
    end
  end

  assign o_count  = r_count;
  assign o_borrow = i_dec && (r_count == 8'd0);

endmodule

// File: rtl/countdown_timer.sv
// HH:MM:SS countdown timer with 1 Hz prescaler, pause/resume and expiry flag.
// Build option: COUNTDOWN_BEEP_EN makes beep toggle on prescaler wraps while expired.
module countdown_timer #(
  parameter int CLK_HZ = 2
) (
  input  logic              clk,
  input  logic              reset,
  countdown_timer_if.slave  bus
);

  import countdown_pkg::*;

  localparam int PW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam logic [PW-1:0] PRESC_TOP = PW'(CLK_HZ - 1);

  cd_state_t     r_state;
  logic [PW-1:0] r_presc;
  logic          r_running;
  logic          r_expired;
  logic          r_beep;

  logic [7:0] w_hrs;
  logic [7:0] w_min;
  logic [7:0] w_sec;
  logic       w_sec_borrow;
  logic       w_min_borrow;
  logic       w_hrs_borrow;
  logic [7:0] w_ld_hrs;
  logic [7:0] w_ld_min;
  logic [7:0] w_ld_sec;
  logic       w_presc_top;
  logic       w_zero;
  logic       w_load_acc;
  logic       w_tick;
  logic       w_last;

  // Decode of the current cycle's load, tick and final-second conditions.
  always_comb begin
    w_ld_hrs    = clamp_field(bus.load_hrs, MAX_HRS);
    w_ld_min    = clamp_field(bus.load_min, MAX_MIN);
    w_ld_sec    = clamp_field(bus.load_sec, MAX_SEC);
    w_presc_top = (r_presc == PRESC_TOP);
    w_zero      = (w_hrs == 8'd0) && (w_min == 8'd0) && (w_sec == 8'd0);
    w_load_acc  = bus.load && (r_state != RUN);
    // Gating on !w_zero guarantees the chain can never wrap below 00:00:00.
    w_tick      = (r_state == RUN) && w_presc_top && !w_zero;
    w_last      = w_tick && (w_hrs == 8'd0) && (w_min == 8'd0) && (w_sec == 8'd1);
  end

  down_field u_sec (
    .clk        (clk),
    .reset      (reset),
    .i_dec      (w_tick),
    .i_load     (w_load_acc),
    .i_load_val (w_ld_sec),
    .i_max      (MAX_SEC),
    .o_count    (w_sec),
    .o_borrow   (w_sec_borrow)
  );

  down_field u_min (
    .clk        (clk),
    .reset      (reset),
    .i_dec      (w_sec_borrow),
    .i_load     (w_load_acc),
    .i_load_val (w_ld_min),
    .i_max      (MAX_MIN),
    .o_count    (w_min),
    .o_borrow   (w_min_borrow)
  );

  down_field u_hrs (
    .clk        (clk),
    .reset      (reset),
    .i_dec      (w_min_borrow),
    .i_load     (w_load_acc),
    .i_load_val (w_ld_hrs),
    .i_max      (MAX_HRS),
    .o_count    (w_hrs),
    .o_borrow   (w_hrs_borrow)
  );

  // Control FSM with prescaler and registered status outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= IDLE;
      r_presc   <= '0;
      r_running <= 1'b0;
      r_expired <= 1'b0;
      r_beep    <= 1'b0;
    end else if (w_load_acc) begin
      r_state   <= IDLE;
      r_presc   <= '0;
      r_running <= 1'b0;
      r_expired <= 1'b0;
      r_beep    <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (bus.start && !bus.pause && !w_zero) begin
            r_state   <= RUN;
            r_presc   <= '0;
            r_running <= 1'b1;
          end
        end
        RUN: begin
          if (w_presc_top) begin
            r_presc <= '0;
          end else begin
            r_presc <= r_presc + 1'b1;
          end
          // The pause cycle itself still counts; the prescaler freezes afterwards.
          if (w_last) begin
            r_state   <= EXPIRED;
            r_running <= 1'b0;
            r_expired <= 1'b1;
          end else if (bus.pause) begin
            r_state   <= PAUSED;
            r_running <= 1'b0;
          end
        end
        PAUSED: begin
          if (bus.start && !bus.pause) begin
            r_state   <= RUN;
            r_running <= 1'b1;
          end
        end
        EXPIRED: begin
          if (bus.ack) begin
            r_state   <= IDLE;
            r_presc   <= '0;
            r_expired <= 1'b0;
            r_beep    <= 1'b0;
          end else begin
`ifdef COUNTDOWN_BEEP_EN
            if (w_presc_top) begin
              r_presc <= '0;
              r_beep  <= ~r_beep;
            end else begin
              r_presc <= r_presc + 1'b1;
            end
`else
            r_presc <= '0;
            r_beep  <= 1'b0;
`endif
          end
        end
        default: begin
          r_state   <= IDLE;
          r_presc   <= '0;
          r_running <= 1'b0;
          r_expired <= 1'b0;
          r_beep    <= 1'b0;
        end
      endcase
    end
  end

  assign bus.hrs     = w_hrs;
  assign bus.min     = w_min;
  assign bus.sec     = w_sec;
  assign bus.running = r_running;
  assign bus.expired = r_expired;
  assign bus.beep    = r_beep;

endmodule

// File: tb/tb_countdown_timer.sv
// Self-checking bench for countdown_timer (CLK_HZ = 2): directed vector table,
// hand-written pause/expiry sequence, and randomized stimulus against a seconds-based model.
module tb_countdown_timer;

  localparam int HZ = 2;

  logic clk;
  logic reset;
  countdown_timer_if cif ();

  countdown_timer #(.CLK_HZ(HZ)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (cif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: remaining time as a single count of seconds.
  int m_total;
  int m_st;     // 0 idle, 1 run, 2 paused, 3 expired
  int m_ph;
  bit m_beep;

  typedef struct {
    bit         rst, ld;
    logic [7:0] h, m, s;
    bit         st, pa, ak;
    logic [7:0] eh, em, es;
    bit         er, ee;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(bit rst, bit ld, int h, int m, int s, bit st, bit pa, bit ak,
                              int eh, int em, int es, bit er, bit ee);
    vec_t v;
    v.rst = rst; v.ld = ld; v.h = 8'(h); v.m = 8'(m); v.s = 8'(s);
    v.st = st; v.pa = pa; v.ak = ak;
    v.eh = 8'(eh); v.em = 8'(em); v.es = 8'(es); v.er = er; v.ee = ee;
    return v;
  endfunction

  task automatic drive(bit rst, bit ld, int h, int m, int s, bit st, bit pa, bit ak);
    reset = rst; cif.load = ld;
    cif.load_hrs = 8'(h); cif.load_min = 8'(m); cif.load_sec = 8'(s);
    cif.start = st; cif.pause = pa; cif.ack = ak;
  endtask

  task automatic model_step();
    int ch, cm, cs;
    if (reset) begin
      m_total = 0; m_st = 0; m_ph = 0; m_beep = 1'b0;
    end else if (cif.load && m_st != 1) begin
      ch = (cif.load_hrs > 23) ? 23 : int'(cif.load_hrs);
      cm = (cif.load_min > 59) ? 59 : int'(cif.load_min);
      cs = (cif.load_sec > 59) ? 59 : int'(cif.load_sec);
      m_total = ch * 3600 + cm * 60 + cs;
      m_st = 0; m_ph = 0; m_beep = 1'b0;
    end else begin
      case (m_st)
        0: if (cif.start && !cif.pause && m_total > 0) begin m_st = 1; m_ph = 0; end
        1: begin
          if (m_ph == HZ - 1) begin
            m_ph = 0;
            m_total = m_total - 1;
          end else begin
            m_ph = m_ph + 1;
          end
          if (m_total == 0) m_st = 3;
          else if (cif.pause) m_st = 2;
        end
        2: if (cif.start && !cif.pause) m_st = 1;
        default: begin
          if (cif.ack) begin
            m_st = 0; m_ph = 0; m_beep = 1'b0;
          end else begin
`ifdef COUNTDOWN_BEEP_EN
            if (m_ph == HZ - 1) begin m_ph = 0; m_beep = ~m_beep; end
            else m_ph = m_ph + 1;
`endif
          end
        end
      endcase
    end
  endtask

  task automatic check_model(string tag);
    logic [26:0] act, exp;
    act = {cif.hrs, cif.min, cif.sec, cif.running, cif.expired, cif.beep};
    exp = {8'(m_total / 3600), 8'((m_total / 60) % 60), 8'(m_total % 60),
           (m_st == 1), (m_st == 3), m_beep};
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d:%0d:%0d run=%b exp=%b beep=%b, want %0d:%0d:%0d run=%b exp=%b beep=%b",
               tag, act[26:19], act[18:11], act[10:3], act[2], act[1], act[0],
               exp[26:19], exp[18:11], exp[10:3], exp[2], exp[1], exp[0]);
    end
  endtask

  task automatic chk(string tag, int act, int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, want %0d", tag, act, exp);
    end
  endtask

  // One clock: model follows the edge, outputs are sampled on the falling edge.
  task automatic cycle(string tag);
    @(posedge clk);
    model_step();
    @(negedge clk);
    check_model(tag);
  endtask

  initial begin
    int toggles;
    bit prev_beep;
    bit seen;

    drive(1'b1, 0, 0, 0, 0, 0, 0, 0);

    // rst ld  h  m  s  st pa ak  ->  eh em es run exp
    tbl.push_back(mk(1, 0,  0,  0,  0, 0, 0, 0,   0,  0,  0, 0, 0));
    tbl.push_back(mk(0, 1,  0,  0,  3, 0, 0, 0,   0,  0,  3, 0, 0));
    tbl.push_back(mk(0, 0,  0,  0,  0, 1, 0, 0,   0,  0,  3, 1, 0));
    tbl.push_back(mk(0, 0,  0,  0,  0, 0, 0, 0,   0,  0,  3, 1, 0));
    tbl.push_back(mk(0, 0,  0,  0,  0, 0, 0, 0,   0,  0,  2, 1, 0));
    tbl.push_back(mk(0, 0,  0,  0,  0, 0, 0, 0,   0,  0,  2, 1, 0));
    tbl.push_back(mk(0, 0,  0,  0,  0, 0, 0, 0,   0,  0,  1, 1, 0));
    tbl.push_back(mk(0, 0,  0,  0,  0, 0, 0, 0,   0,  0,  1, 1, 0));
    tbl.push_back(mk(0, 0,  0,  0,  0, 0, 0, 0,   0,  0,  0, 0, 1));
    tbl.push_back(mk(0, 0,  0,  0,  0, 1, 0, 0,   0,  0,  0, 0, 1));
    tbl.push_back(mk(0, 0,  0,  0,  0, 0, 1, 0,   0,  0,  0, 0, 1));
    tbl.push_back(mk(0, 0,  0,  0,  0, 0, 0, 1,   0,  0,  0, 0, 0));
    tbl.push_back(mk(0, 1, 30, 75, 99, 0, 0, 0,  23, 59, 59, 0, 0));
    tbl.push_back(mk(0, 1,  0,  0,  0, 0, 0, 0,   0,  0,  0, 0, 0));
    tbl.push_back(mk(0, 0,  0,  0,  0, 1, 0, 0,   0,  0,  0, 0, 0));
    tbl.push_back(mk(0, 1,  1,  0,  0, 0, 0, 0,   1,  0,  0, 0, 0));
    tbl.push_back(mk(0, 0,  0,  0,  0, 1, 0, 0,   1,  0,  0, 1, 0));
    tbl.push_back(mk(0, 0,  0,  0,  0, 0, 0, 0,   1,  0,  0, 1, 0));
    tbl.push_back(mk(0, 0,  0,  0,  0, 0, 0, 0,   0, 59, 59, 1, 0));
    tbl.push_back(mk(0, 0,  0,  0,  0, 0, 0, 0,   0, 59, 59, 1, 0));
    tbl.push_back(mk(0, 0,  0,  0,  0, 0, 0, 0,   0, 59, 58, 1, 0));
    tbl.push_back(mk(0, 1,  5,  5,  5, 0, 0, 0,   0, 59, 58, 1, 0));
    tbl.push_back(mk(0, 1, 12, 34, 56, 0, 0, 0,   0, 59, 57, 1, 0));
    tbl.push_back(mk(1, 0,  0,  0,  0, 0, 0, 0,   0,  0,  0, 0, 0));
    tbl.push_back(mk(0, 1, 12, 34, 56, 0, 0, 0,  12, 34, 56, 0, 0));
    tbl.push_back(mk(0, 0,  0,  0,  0, 1, 0, 0,  12, 34, 56, 1, 0));
    tbl.push_back(mk(0, 1,  0,  0,  1, 0, 0, 0,  12, 34, 56, 1, 0));
    tbl.push_back(mk(1, 0,  0,  0,  0, 0, 0, 0,   0,  0,  0, 0, 0));

    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i].rst, tbl[i].ld, tbl[i].h, tbl[i].m, tbl[i].s, tbl[i].st, tbl[i].pa, tbl[i].ak);
      cycle($sformatf("tbl%0d_model", i));
      n_checks++;
      if ({cif.hrs, cif.min, cif.sec, cif.running, cif.expired} !==
          {tbl[i].eh, tbl[i].em, tbl[i].es, tbl[i].er, tbl[i].ee}) begin
        n_fail++;
        $display("FAIL tbl%0d: got %0d:%0d:%0d run=%b exp=%b, want %0d:%0d:%0d run=%b exp=%b",
                 i, cif.hrs, cif.min, cif.sec, cif.running, cif.expired,
                 tbl[i].eh, tbl[i].em, tbl[i].es, tbl[i].er, tbl[i].ee);
      end
    end

    // Pause/resume: load 5 s, start, pause on the third cycle after start.
    drive(0, 1, 0, 0, 5, 0, 0, 0); cycle("p_load");
    drive(0, 0, 0, 0, 0, 1, 0, 0); cycle("p_start");
    drive(0, 0, 0, 0, 0, 0, 0, 0); cycle("p_run1");
    cycle("p_run2");
    drive(0, 0, 0, 0, 0, 0, 1, 0); cycle("p_pause");
    chk("pause_running", cif.running, 0);
    drive(0, 0, 0, 0, 0, 0, 0, 1);
    for (int i = 0; i < 20; i++) begin
      cycle("p_frozen");
      chk("frozen_sec", cif.sec, 4);
      drive(0, 0, 0, 0, 0, 0, 0, 0);
    end
    drive(0, 0, 0, 0, 0, 1, 0, 0); cycle("p_resume");
    chk("resume_running", cif.running, 1);
    chk("resume_sec_hold", cif.sec, 4);
    drive(0, 0, 0, 0, 0, 0, 0, 0); cycle("p_next");
    chk("resume_first_dec", cif.sec, 3);

    // Expiry must arrive within a bounded number of cycles (3 s = 6 cycles).
    seen = 1'b0;
    for (int i = 0; i < 12 && !seen; i++) begin
      cycle("p_wait");
      seen = cif.expired;
      if (seen) chk("expire_cycle", i, 5);
    end
    chk("expired_seen", seen, 1);
    chk("expired_time", {cif.hrs, cif.min, cif.sec}, 0);

    // While expired: start/pause ignored, beep cadence.
    toggles = 0;
    prev_beep = cif.beep;
    for (int i = 0; i < 6; i++) begin
      drive(0, 0, 0, 0, 0, i[0], ~i[0], 0);
      cycle("e_hold");
      chk("e_hold_expired", cif.expired, 1);
      if (cif.beep != prev_beep) toggles++;
      prev_beep = cif.beep;
    end
`ifdef COUNTDOWN_BEEP_EN
    chk("beep_toggles", toggles, 3);
`else
    chk("beep_toggles", toggles, 0);
`endif
    drive(0, 0, 0, 0, 0, 0, 0, 1); cycle("e_ack");
    chk("ack_expired", cif.expired, 0);
    chk("ack_beep", cif.beep, 0);

    // Randomized stimulus against the model.
    for (int i = 0; i < 3000; i++) begin
      drive(($urandom % 200) == 0,
            ($urandom % 20) == 0,
            (($urandom % 8) == 0) ? ($urandom % 256) : 0,
            (($urandom % 4) == 0) ? ($urandom % 100) : ($urandom % 2),
            (($urandom % 8) == 0) ? ($urandom % 256) : ($urandom % 12),
            ($urandom % 4) == 0,
            ($urandom % 16) == 0,
            ($urandom % 8) == 0);
      cycle("rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
